// File: rtl/run_control.sv
// Debug-side run controller: turns debug command bytes into continuous-run or
// single-step enable patterns for the gated-clock stage, and counts enabled cycles.
module run_control #(
  parameter int unsigned NBITS     = 32,
  parameter logic [7:0]  CMD_RUN   = 8'h43,
  parameter logic [7:0]  CMD_STEP  = 8'h53,
  parameter logic [7:0]  CMD_PAUSE = 8'h50,
  parameter logic [7:0]  CMD_CLEAR = 8'h52
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       i_cmd,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_halt,
  output logic             o_enable,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_done,
  output logic [NBITS-1:0] o_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED
  } state_t;

  localparam logic [NBITS-1:0] CYCLES_MAX = '1;

  state_t state_q;
  state_t state_d;
  logic   cmd_fire;
  logic   clear_cnt;
  logic   busy_now;
  logic   busy_next;

  // Only STEP refuses commands; it is a fixed one-cycle state.
  assign o_cmd_ready = (state_q != ST_STEP);
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign busy_now    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign busy_next   = (state_d == ST_RUN) || (state_d == ST_STEP);

  // Next-state logic; halt outranks PAUSE while running.
  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (i_cmd == CMD_RUN) begin
            state_d = ST_RUN;
          end else if (i_cmd == CMD_STEP) begin
            state_d = ST_STEP;
          end else if (i_cmd == CMD_CLEAR) begin
            clear_cnt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          state_d = ST_HALTED;
        end else if (cmd_fire && (i_cmd == CMD_PAUSE)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        state_d = i_halt ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        if (cmd_fire && (i_cmd == CMD_CLEAR)) begin
          state_d   = ST_IDLE;
          clear_cnt = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; status outputs are registered from the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      o_enable <= 1'b0;
      o_busy   <= 1'b0;
      o_halted <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state_q  <= state_d;
      o_enable <= busy_next;
      o_busy   <= busy_next;
      o_halted <= (state_d == ST_HALTED);
      o_done   <= busy_now && !busy_next;
    end
  end

  // Saturating count of enabled cycles; clear wins over increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_cycles <= '0;
    end else if (clear_cnt) begin
      o_cycles <= '0;
    end else if (o_enable && (o_cycles != CYCLES_MAX)) begin
      o_cycles <= o_cycles + NBITS'(1);
    end
  end

endmodule

// File: tb/tb_run_control.sv
// Bench for run_control: directed scenarios plus random command traffic,
// checked cycle by cycle against a behavioural model.
module tb_run_control;

  localparam int unsigned NBITS   = 4;
  localparam int unsigned CNT_MAX = (1 << NBITS) - 1;
  localparam logic [7:0] CMD_RUN   = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_CLEAR = 8'h52;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STEP   = 2;
  localparam int M_HALTED = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       i_cmd = 8'h00;
  logic             i_cmd_valid = 1'b0;
  logic             o_cmd_ready;
  logic             i_halt = 1'b0;
  logic             o_enable;
  logic             o_busy;
  logic             o_halted;
  logic             o_done;
  logic [NBITS-1:0] o_cycles;

  int n_cmp = 0;
  int n_err = 0;
  int en_seen = 0;
  int done_seen = 0;

  int m_mode = M_IDLE;
  int m_cycles = 0;
  bit m_done = 1'b0;

  run_control #(.NBITS(NBITS)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_cmd       (i_cmd),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_halt      (i_halt),
    .o_enable    (o_enable),
    .o_busy      (o_busy),
    .o_halted    (o_halted),
    .o_done      (o_done),
    .o_cycles    (o_cycles)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_cycles = 0;
    m_done   = 1'b0;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic cycle(input bit v, input logic [7:0] c, input bit h);
    bit busy_before;
    bit busy_after;
    bit fire;
    int nxt;
    @(negedge clock);
    busy_before = (m_mode == M_RUN) || (m_mode == M_STEP);
    check_eq("enable", 32'(o_enable), 32'(busy_before));
    check_eq("busy",   32'(o_busy),   32'(busy_before));
    check_eq("halted", 32'(o_halted), 32'(m_mode == M_HALTED));
    check_eq("done",   32'(o_done),   32'(m_done));
    check_eq("ready",  32'(o_cmd_ready), 32'(m_mode != M_STEP));
    check_eq("cycles", 32'(o_cycles), 32'(m_cycles));
    en_seen   += int'(o_enable);
    done_seen += int'(o_done);
    i_cmd_valid = v;
    i_cmd       = c;
    i_halt      = h;
    fire = v && (m_mode != M_STEP);
    nxt  = m_mode;
    case (m_mode)
      M_IDLE: begin
        if (fire && c == CMD_RUN) nxt = M_RUN;
        else if (fire && c == CMD_STEP) nxt = M_STEP;
      end
      M_RUN: begin
        if (h) nxt = M_HALTED;
        else if (fire && c == CMD_PAUSE) nxt = M_IDLE;
      end
      M_STEP: nxt = h ? M_HALTED : M_IDLE;
      default: if (fire && c == CMD_CLEAR) nxt = M_IDLE;
    endcase
    if (fire && c == CMD_CLEAR && !busy_before) m_cycles = 0;
    else if (busy_before && m_cycles < CNT_MAX) m_cycles = m_cycles + 1;
    busy_after = (nxt == M_RUN) || (nxt == M_STEP);
    m_done = busy_before && !busy_after;
    m_mode = nxt;
  endtask

  initial begin
    // Reset held for two cycles.
    #1;
    check_eq("rst_async_enable", 32'(o_enable), 32'd0);
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_enable", 32'(o_enable), 32'd0);
    check_eq("rst_busy",   32'(o_busy),   32'd0);
    check_eq("rst_halted", 32'(o_halted), 32'd0);
    check_eq("rst_done",   32'(o_done),   32'd0);
    check_eq("rst_cycles", 32'(o_cycles), 32'd0);
    check_eq("rst_ready",  32'(o_cmd_ready), 32'd1);
    reset = 1'b1;
    model_reset();

    // Three single steps, three cycles apart.
    en_seen = 0; done_seen = 0;
    repeat (3) begin
      cycle(1, CMD_STEP, 0);
      cycle(0, 8'h00, 0);
      cycle(0, 8'h00, 0);
    end
    cycle(0, 8'h00, 0);
    check_eq("step_en_cycles", 32'(en_seen), 32'd3);
    check_eq("step_done_pulses", 32'(done_seen), 32'd3);
    check_eq("step_cycles", 32'(o_cycles), 32'd3);

    // Run, halt ten cycles after acceptance, then a STEP that must be ignored.
    cycle(1, CMD_CLEAR, 0);
    en_seen = 0; done_seen = 0;
    cycle(1, CMD_RUN, 0);
    repeat (9) cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 1);
    cycle(1, CMD_STEP, 0);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 0);
    check_eq("halt_en_cycles", 32'(en_seen), 32'd10);
    check_eq("halt_done_pulses", 32'(done_seen), 32'd1);
    check_eq("halt_cycles", 32'(o_cycles), 32'd10);
    check_eq("halt_halted", 32'(o_halted), 32'd1);

    // PAUSE and halt on the same edge end in HALTED; CLEAR recovers.
    cycle(1, CMD_CLEAR, 0);
    cycle(1, CMD_RUN, 0);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 0);
    cycle(1, CMD_PAUSE, 1);
    cycle(0, 8'h00, 0);
    check_eq("collide_halted", 32'(o_halted), 32'd1);
    check_eq("collide_busy", 32'(o_busy), 32'd0);
    cycle(1, CMD_CLEAR, 0);
    cycle(0, 8'h00, 0);
    check_eq("clear_cycles", 32'(o_cycles), 32'd0);
    check_eq("clear_halted", 32'(o_halted), 32'd0);

    // Counter saturation.
    cycle(1, CMD_RUN, 0);
    repeat (20) cycle(0, 8'h00, 0);
    cycle(1, CMD_PAUSE, 0);
    cycle(0, 8'h00, 0);
    check_eq("sat_cycles", 32'(o_cycles), 32'(CNT_MAX));
    check_eq("sat_busy", 32'(o_busy), 32'd0);

    // Handshake: RUN offered during STEP is held off, then accepted.
    cycle(1, CMD_STEP, 0);
    cycle(1, CMD_RUN, 0);
    cycle(1, CMD_RUN, 0);
    cycle(0, 8'h00, 0);
    check_eq("hs_run_busy", 32'(o_busy), 32'd1);
    check_eq("hs_run_enable", 32'(o_enable), 32'd1);
    cycle(1, CMD_PAUSE, 0);
    cycle(1, 8'h00, 0);
    cycle(0, 8'h00, 0);
    check_eq("unknown_busy", 32'(o_busy), 32'd0);
    check_eq("unknown_ready", 32'(o_cmd_ready), 32'd1);

    // Reset during RUN drops enable before the next edge.
    cycle(1, CMD_RUN, 0);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 0);
    check_eq("midrun_enable_before", 32'(o_enable), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("midrun_rst_enable", 32'(o_enable), 32'd0);
    check_eq("midrun_rst_cycles", 32'(o_cycles), 32'd0);
    check_eq("midrun_rst_ready", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b0;
    i_halt = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // Random command traffic.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [7:0] c;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: c = CMD_RUN;
        3, 4:    c = CMD_STEP;
        5, 6:    c = CMD_PAUSE;
        7:       c = CMD_CLEAR;
        default: c = 8'($urandom);
      endcase
      cycle(bit'($urandom_range(0, 1)), c, ($urandom_range(0, 9) == 0));
    end
    cycle(0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/run_control.md
# run_control

Debug-side run controller that generates the `enable` input of the gated-clock stage (`clock_control`) in the pipelined processor. It turns byte commands from the debug unit into continuous-run or single-step enable patterns. It stops the pipeline when the processor reports a halt instruction, and it keeps its own count of enabled cycles for reporting back over the debug link.

## Interface
- `NBITS`, 32, width of the enabled-cycle counter `o_cycles`
- `CMD_RUN`, 8'h43 ('C'), command: continuous run
- `CMD_STEP`, 8'h53 ('S'), command: single step
- `CMD_PAUSE`, 8'h50 ('P'), command: pause a continuous run
- `CMD_CLEAR`, 8'h52 ('R'), command: clear counter and halted state

Ports:
- `clock`  in  1  system clock; single clock domain; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `i_cmd`  in  8  command byte from debug unit
- `i_cmd_valid`  in  1  `i_cmd` valid this cycle
- `o_cmd_ready`  out  1  controller can consume a command this cycle
- `i_halt`  in  1  processor reports HALT retired (level, sampled on rising edge)
- `o_enable`  out  1  registered enable to `clock_control`
- `o_busy`  out  1  state is RUN or STEP
- `o_halted`  out  1  state is HALTED
- `o_done`  out  1  one-cycle pulse: a run or step just ended
- `o_cycles`  out  NBITS  number of cycles with `o_enable`=1 since the last clear

## Operation
- FSM states: IDLE, RUN, STEP, HALTED.
- A command is accepted at a rising edge where `i_cmd_valid`=1 and `o_cmd_ready`=1.
- A command that is accepted but not meaningful in the current state is consumed and ignored.
- `o_cmd_ready` is 1 in IDLE, RUN and HALTED, and 0 in STEP.
- IDLE:
  - RUN cmd -> RUN.
  - STEP cmd -> STEP.
  - CLEAR cmd -> stay in IDLE; `o_cycles` set to 0.
  - PAUSE and unknown commands are ignored.
- RUN:
  - `o_enable`=1 every cycle.
  - `i_halt`=1 -> HALTED.
  - Otherwise, PAUSE cmd -> IDLE.
  - All other commands are ignored.
- STEP:
  - Lasts exactly one cycle with `o_enable`=1.
  - Exits to HALTED if `i_halt`=1 at that edge, else to IDLE.
- HALTED:
  - `o_enable`=0.
  - Only CLEAR leaves: -> IDLE with `o_cycles` set to 0. Every other command is ignored.
- `o_done` pulses on every exit from RUN or STEP: RUN->HALTED, RUN->IDLE, STEP->IDLE, STEP->HALTED.
- Counter:
  - `o_cycles` increments by 1 at every rising edge where `o_enable`=1.
  - It saturates at 2^NBITS-1 and never wraps.
  - CLEAR has priority over an increment in the same edge (not reachable in practice, since CLEAR is only honoured when `o_enable`=0).
- Simultaneous events in RUN: `i_halt` wins over PAUSE, giving HALTED.
- `i_halt` is ignored in IDLE and HALTED.

## Timing
- Reset (`reset`=0) is asynchronous and takes effect immediately. Reset values:
  - state IDLE
  - `o_enable`=0, `o_busy`=0, `o_halted`=0, `o_done`=0
  - `o_cycles`=0
  - `o_cmd_ready`=1 (combinational from state)
- Reset asserted mid-run drops `o_enable` without waiting for a clock edge.
- `o_enable`, `o_busy`, `o_halted` and `o_done` are registered. They reflect the state entered at the preceding edge.
- RUN accepted at edge k:
  - `o_enable`=1 from cycle k+1.
  - If `i_halt` or PAUSE is seen at edge m, `o_enable`=0 and `o_done`=1 during cycle m+1.
- STEP accepted at edge k:
  - `o_enable`=1 during cycle k+1 only.
  - `o_done`=1 during cycle k+2.
  - `o_cycles` is +1 after edge k+1.
- A new command can be accepted at edge k+2 after a STEP, because `o_cmd_ready`=1 again in cycle k+2.
- Latency from command to enable is always one cycle.
- No combinational path from `i_halt` or `i_cmd` to `o_enable`.

## Test plan
- Reset behaviour: hold `reset`=0 for 2 cycles -> all outputs 0 except `o_cmd_ready`=1. Then assert `reset`=0 during RUN -> `o_enable` falls before the next edge.
- Single step: send STEP 3 times, 3 cycles apart -> `o_enable` high for exactly 3 isolated cycles, 3 `o_done` pulses, `o_cycles`=3.
- Run then halt: send RUN, raise `i_halt` 10 cycles after acceptance -> `o_enable` high for 10 cycles, `o_cycles`=10, `o_halted`=1, one `o_done` pulse. A subsequent STEP is ignored (`o_enable` stays 0).
- Pause and halt collision: in RUN, PAUSE and `i_halt` on the same edge -> state HALTED, not IDLE. Then CLEAR -> IDLE, `o_cycles`=0, `o_halted`=0.
- Saturation: with NBITS=4, RUN for 20 cycles -> `o_cycles` stops at 15.
- Handshake: assert `i_cmd_valid` with RUN during STEP -> not accepted (`o_cmd_ready`=0), then accepted in the next cycle. An unknown byte 8'h00 in IDLE -> consumed, no state change.
